// File: rtl/pc_trace_monitor.sv
// pc_trace_monitor: run-outcome monitor with circular PC history dump.
// Define PC_TRACE_STOP_EN to add the stopPc / debugStop PC breakpoint.
module pc_trace_monitor #(
    parameter int          XLEN           = 32,
    parameter int          DEPTH          = 10,
    parameter int          TIMEOUT_CYCLES = 49999,
    parameter logic [31:0] PASS_INSTR     = 32'h00000073,
    parameter logic [31:0] FAIL_INSTR     = 32'h00100073
) (
    input  logic                       sysClk,
    input  logic                       sysRes,
    input  logic                       fetchValid,
    input  logic [XLEN-1:0]            pcIn,
    input  logic [31:0]                instrIn,
`ifdef PC_TRACE_STOP_EN
    input  logic [XLEN-1:0]            stopPc,
    output logic                       debugStop,
`endif
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [$clog2(DEPTH+1)-1:0] histCount,
    output logic                       dumpValid,
    output logic [XLEN-1:0]            dumpData,
    output logic                       dumpLast,
    input  logic                       dumpReady
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-1);

    typedef enum logic [1:0] {
        RUN,
        DUMP,
        HALT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] hist_q [DEPTH];
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   histCount_q, histCount_d;
    logic [CW-1:0]   remain_q, remain_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic            tmo_q, tmo_d;
    logic            dumpValid_q, dumpValid_d;
    logic            dumpLast_q, dumpLast_d;
    logic [XLEN-1:0] dumpData_q, dumpData_d;
`ifdef PC_TRACE_STOP_EN
    logic            stop_q, stop_d;
    logic            isStop;
`endif

    logic          isPass;
    logic          isFail;
    logic          isTmo;
    logic          goDump;
    logic [PW-1:0] wrNext;
    logic [PW-1:0] rdNext;
    logic [CW-1:0] cntUp;

    assign isPass = fetchValid && (instrIn == PASS_INSTR);
    assign isFail = fetchValid && (instrIn == FAIL_INSTR);
    assign isTmo  = (cnt_q == TMO_LAST);
`ifdef PC_TRACE_STOP_EN
    assign isStop = fetchValid && (pcIn == stopPc);
`endif

    assign wrNext = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PW'(1);
    assign rdNext = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PW'(1);
    assign cntUp  = (histCount_q == CNT_FULL) ? histCount_q
                                              : histCount_q + CW'(1);

    // Next-state: logging and outcome in RUN, history streaming in DUMP.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        histCount_d = histCount_q;
        remain_d    = remain_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        tmo_d       = tmo_q;
        dumpValid_d = dumpValid_q;
        dumpLast_d  = dumpLast_q;
        dumpData_d  = dumpData_q;
`ifdef PC_TRACE_STOP_EN
        stop_d      = stop_q;
`endif
        goDump      = 1'b0;
        case (state_q)
            RUN: begin
                cnt_d = cnt_q + TW'(1);
                if (fetchValid) begin
                    wrPtr_d     = wrNext;
                    histCount_d = cntUp;
                end
                if (isPass) begin
                    state_d = HALT;
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                end else if (isFail) begin
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                    goDump  = 1'b1;
`ifdef PC_TRACE_STOP_EN
                end else if (isStop) begin
                    state_d = HALT;
                    stop_d  = 1'b1;
                    done_d  = 1'b1;
`endif
                end else if (isTmo) begin
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    goDump  = 1'b1;
                end
                // Oldest entry is slot 0 until the buffer has wrapped.
                if (goDump) begin
                    rdPtr_d  = (histCount_d == CNT_FULL) ? wrPtr_d : '0;
                    remain_d = histCount_d;
                    state_d  = (histCount_d == '0) ? HALT : DUMP;
                end
            end
            DUMP: begin
                if (!dumpValid_q) begin
                    dumpValid_d = 1'b1;
                    dumpData_d  = hist_q[rdPtr_q];
                    dumpLast_d  = (remain_q == CW'(1));
                end else if (dumpReady) begin
                    if (dumpLast_q) begin
                        dumpValid_d = 1'b0;
                        dumpLast_d  = 1'b0;
                        state_d     = HALT;
                    end else begin
                        rdPtr_d    = rdNext;
                        remain_d   = remain_q - CW'(1);
                        dumpData_d = hist_q[rdNext];
                        dumpLast_d = (remain_q == CW'(2));
                    end
                end
            end
            HALT: begin
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge sysClk) begin
        if (!sysRes) begin
            state_q     <= RUN;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            histCount_q <= '0;
            remain_q    <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            tmo_q       <= 1'b0;
            dumpValid_q <= 1'b0;
            dumpLast_q  <= 1'b0;
            dumpData_q  <= '0;
`ifdef PC_TRACE_STOP_EN
            stop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            histCount_q <= histCount_d;
            remain_q    <= remain_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            tmo_q       <= tmo_d;
            dumpValid_q <= dumpValid_d;
            dumpLast_q  <= dumpLast_d;
            dumpData_q  <= dumpData_d;
`ifdef PC_TRACE_STOP_EN
            stop_q      <= stop_d;
`endif
        end
    end

    // History RAM: logs every fetched PC while running, no reset needed.
    always_ff @(posedge sysClk) begin
        if (sysRes && state_q == RUN && fetchValid) begin
            hist_q[wrPtr_q] <= pcIn;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = tmo_q;
    assign histCount = histCount_q;
    assign dumpValid = dumpValid_q;
    assign dumpData  = dumpData_q;
    assign dumpLast  = dumpLast_q;
`ifdef PC_TRACE_STOP_EN
    assign debugStop = stop_q;
`endif

endmodule

// File: tb/tb_pc_trace_monitor.sv
// tb_pc_trace_monitor: directed table plus random runs against a queue model.
// Optional PC_TRACE_STOP_EN adds the stop-PC scenario.
module tb_pc_trace_monitor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 10;
    localparam int TMO   = 60;
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [31:0] PASS_I = 32'h00000073;
    localparam logic [31:0] FAIL_I = 32'h00100073;
    localparam logic [31:0] NOP_I  = 32'h00000013;
`ifdef PC_TRACE_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic            sysClk = 1'b0;
    logic            sysRes = 1'b0;
    logic            fetchValid = 1'b0;
    logic [XLEN-1:0] pcIn = '0;
    logic [31:0]     instrIn = '0;
    logic            dumpReady = 1'b0;
    logic            done, pass, fail, timeout;
    logic [CW-1:0]   histCount;
    logic            dumpValid, dumpLast;
    logic [XLEN-1:0] dumpData;
`ifdef PC_TRACE_STOP_EN
    logic [XLEN-1:0] stopPc = '1;
    logic            debugStop;
`endif

    pc_trace_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO),
        .PASS_INSTR(PASS_I), .FAIL_INSTR(FAIL_I)
    ) dut (
        .sysClk(sysClk), .sysRes(sysRes), .fetchValid(fetchValid),
        .pcIn(pcIn), .instrIn(instrIn),
`ifdef PC_TRACE_STOP_EN
        .stopPc(stopPc), .debugStop(debugStop),
`endif
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .histCount(histCount), .dumpValid(dumpValid),
        .dumpData(dumpData), .dumpLast(dumpLast), .dumpReady(dumpReady)
    );

    always #5 sysClk = ~sysClk;

    int errors = 0;
    int checks = 0;

    // stimulus per RUN cycle (index k-1 for edge k)
    bit          s_fv[$];
    logic [31:0] s_pc[$];
    logic [31:0] s_in[$];
    logic [31:0] s_stop = 32'hFFFF_FFFF;

    // model results
    int          m_end, m_out, m_cnt;
    logic [31:0] m_log[$];
    logic [31:0] m_dump[$];

    // observed dump
    logic [31:0] g_dump[$];
    bit          g_last[$];

    typedef struct {
        string       name;
        int          n;
        logic [31:0] last_ins;
        logic [31:0] stop;
        int          rmode;
        int          exp_out;
        int          exp_cnt;
        int          exp_nd;
        logic [31:0] exp_first;
    } row_t;

    row_t rows[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Outcome: 0 pass, 1 fail, 2 timeout, 3 stop; first halting rule wins.
    function automatic void model();
        m_log.delete();
        m_dump.delete();
        m_out = -1;
        m_end = 0;
        for (int k = 1; k <= TMO; k++) begin
            if (k <= s_fv.size() && s_fv[k-1]) begin
                m_log.push_back(s_pc[k-1]);
                if (s_in[k-1] == PASS_I) m_out = 0;
                else if (s_in[k-1] == FAIL_I) m_out = 1;
                else if (STOP_EN && s_pc[k-1] == s_stop) m_out = 3;
            end
            if (m_out < 0 && k == TMO) m_out = 2;
            if (m_out >= 0) begin
                m_end = k;
                break;
            end
        end
        m_cnt = (m_log.size() < DEPTH) ? m_log.size() : DEPTH;
        if (m_out == 1 || m_out == 2)
            for (int i = m_log.size() - m_cnt; i < m_log.size(); i++)
                m_dump.push_back(m_log[i]);
    endfunction

    function automatic int act_out();
        if (pass) return 0;
        if (fail) return 1;
        if (timeout) return 2;
`ifdef PC_TRACE_STOP_EN
        if (debugStop) return 3;
`endif
        return 9;
    endfunction

    task automatic do_reset(input bit check);
        sysRes = 1'b0;
        fetchValid = 1'b0;
        dumpReady = 1'b0;
        repeat (2) @(posedge sysClk);
        #1;
        if (check) begin
            chk("rst_flags", {done, pass, fail, timeout, dumpValid, dumpLast}, 0);
            chk("rst_cnt", histCount, 0);
            chk("rst_data", dumpData, 0);
        end
        sysRes = 1'b1;
    endtask

    task automatic drive_k(input int k);
        if (k <= s_fv.size()) begin
            fetchValid = s_fv[k-1];
            pcIn = s_pc[k-1];
            instrIn = s_in[k-1];
        end else begin
            fetchValid = 1'b0;
            pcIn = $urandom;
            instrIn = $urandom_range(0, 1) ? PASS_I : 32'($urandom);
        end
`ifdef PC_TRACE_STOP_EN
        stopPc = s_stop;
`endif
    endtask

    task automatic build_row(input int n, input logic [31:0] last_ins);
        s_fv.delete();
        s_pc.delete();
        s_in.delete();
        for (int i = 0; i < n; i++) begin
            s_fv.push_back(1'b1);
            s_pc.push_back(32'(i * 4));
            s_in.push_back(i == n - 1 ? last_ins : NOP_I);
        end
    endtask

    task automatic run_phase();
        bit early = 0;
        bit hbad = 0;
        int logged = 0;
        model();
        for (int k = 1; k <= m_end; k++) begin
            drive_k(k);
            dumpReady = 1'($urandom_range(0, 1));
            @(posedge sysClk);
            #1;
            if (k <= s_fv.size() && s_fv[k-1]) logged++;
            if (k < m_end && done) early = 1;
            if (histCount !== CW'(logged < DEPTH ? logged : DEPTH)) hbad = 1;
        end
        chk("early_done", early, 0);
        chk("hist_track", hbad, 0);
        chk("done", done, 1);
        chk("flags", {pass, fail, timeout},
            {m_out == 0, m_out == 1, m_out == 2});
`ifdef PC_TRACE_STOP_EN
        chk("debugStop", debugStop, m_out == 3);
`endif
        chk("histCount", histCount, m_cnt);
    endtask

    task automatic dump_phase(input int rmode);
        bit sbad = 0;
        bit pv = 0;
        bit pr = 0;
        bit pl = 0;
        logic [31:0] pd = '0;
        g_dump.delete();
        g_last.delete();
        for (int c = 0; c < 80; c++) begin
            fetchValid = 1'($urandom_range(0, 1));
            pcIn = $urandom;
            instrIn = $urandom_range(0, 1) ? FAIL_I : PASS_I;
            if (rmode == 0) dumpReady = 1'b1;
            else if (rmode == 1) dumpReady = (c % 2 == 1);
            else dumpReady = 1'($urandom_range(0, 1));
            if (pv && !pr && !(dumpValid && dumpData == pd && dumpLast == pl))
                sbad = 1;
            if (dumpValid && dumpReady) begin
                g_dump.push_back(dumpData);
                g_last.push_back(dumpLast);
            end
            pv = dumpValid;
            pr = dumpReady;
            pd = dumpData;
            pl = dumpLast;
            @(posedge sysClk);
            #1;
        end
        chk("dump_len", g_dump.size(), m_dump.size());
        for (int i = 0; i < g_dump.size() && i < m_dump.size(); i++) begin
            chk("dump_data", g_dump[i], m_dump[i]);
            chk("dump_last", g_last[i], i == m_dump.size() - 1);
        end
        chk("stall_hold", sbad, 0);
        chk("dump_idle", dumpValid, 0);
        chk("held_flags", {done, pass, fail, timeout},
            {1'b1, m_out == 0, m_out == 1, m_out == 2});
        chk("held_cnt", histCount, m_cnt);
    endtask

    initial begin
        int acc;
        rows.push_back('{"ecall",      6, PASS_I, '1, 0, 0,  6,  0, 32'h0});
        rows.push_back('{"ebreak14",  14, FAIL_I, '1, 0, 1, 10, 10, 32'h10});
        rows.push_back('{"ebreak_tog",14, FAIL_I, '1, 1, 1, 10, 10, 32'h10});
        rows.push_back('{"tmo_empty",  0, NOP_I,  '1, 0, 2,  0,  0, 32'h0});
        rows.push_back('{"tmo_three",  3, NOP_I,  '1, 1, 2,  3,  3, 32'h0});
        rows.push_back('{"fail_at_tmo",TMO, FAIL_I,'1, 2, 1, 10, 10, 32'hC8});
        rows.push_back('{"fail_full", 10, FAIL_I, '1, 0, 1, 10, 10, 32'h0});
        rows.push_back('{"fail_wrap1",11, FAIL_I, '1, 2, 1, 10, 10, 32'h4});
`ifdef PC_TRACE_STOP_EN
        rows.push_back('{"stop",       9, NOP_I, 32'h20, 0, 3, 9, 0, 32'h0});
`endif

        do_reset(1'b1);

        foreach (rows[r]) begin
            build_row(rows[r].n, rows[r].last_ins);
            s_stop = rows[r].stop;
            do_reset(1'b0);
            run_phase();
            chk({rows[r].name, "_out"}, act_out(), rows[r].exp_out);
            chk({rows[r].name, "_cnt"}, histCount, rows[r].exp_cnt);
            dump_phase(rows[r].rmode);
            chk({rows[r].name, "_nd"}, g_dump.size(), rows[r].exp_nd);
            if (rows[r].exp_nd > 0)
                chk({rows[r].name, "_first"}, g_dump[0], rows[r].exp_first);
        end
        s_stop = 32'hFFFF_FFFF;

        // reset in the middle of a dump, then a clean ECALL run
        build_row(14, FAIL_I);
        do_reset(1'b0);
        run_phase();
        acc = 0;
        for (int c = 0; c < 40 && acc < 2; c++) begin
            dumpReady = 1'b1;
            if (dumpValid) acc++;
            @(posedge sysClk);
            #1;
        end
        chk("middump_acc", acc, 2);
        sysRes = 1'b0;
        @(posedge sysClk);
        #1;
        chk("middump_flags", {done, pass, fail, timeout, dumpValid, dumpLast}, 0);
        chk("middump_cnt", histCount, 0);
        chk("middump_data", dumpData, 0);
        sysRes = 1'b1;
        build_row(6, PASS_I);
        run_phase();
        dump_phase(0);

        // random runs against the queue model
        for (int t = 0; t < 30; t++) begin
            int len;
            s_fv.delete();
            s_pc.delete();
            s_in.delete();
            s_stop = 32'hFFFF_FFFF;
            len = $urandom_range(0, TMO + 10);
            for (int i = 0; i < len; i++) begin
                int rv;
                logic [31:0] ins;
                rv = $urandom_range(0, 99);
                ins = rv < 4 ? PASS_I : rv < 8 ? FAIL_I : (32'($urandom) | 32'h3);
                if (i == TMO - 1 && ins == PASS_I) ins = NOP_I;
                s_fv.push_back($urandom_range(0, 9) < 7);
                s_pc.push_back(32'($urandom) & 32'h0000_0FFC);
                s_in.push_back(ins);
            end
            if (STOP_EN && len > 0 && $urandom_range(0, 2) == 0)
                s_stop = s_pc[$urandom_range(0, len - 1)];
            do_reset(1'b0);
            run_phase();
            dump_phase(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_trace_monitor.md
# pc_trace_monitor

Synthesizable run monitor for the CPU core: samples each fetched instruction and its PC, keeps a circular history of the last DEPTH PC values, and decides the run outcome (pass on ECALL, fail on EBREAK, timeout on cycle budget). On fail or timeout it streams the PC history oldest-first over a valid/ready port for the bench or a debug UART. It sits beside `top`, tapping the instruction bus and `cpuInst.PC`, and is usable in simulation and on FPGA.

## Interface
- `XLEN`, 32, PC width.
- `DEPTH`, 10, history entries (≥2).
- `TIMEOUT_CYCLES`, 49999, cycles after reset release before timeout.
- `PASS_INSTR`, 32'h00000073, instruction word signalling pass (ECALL).
- `FAIL_INSTR`, 32'h00100073, instruction word signalling fail (EBREAK).

- `sysClk` in 1: clock, all logic on rising edge.
- `sysRes` in 1: synchronous, active-low reset.
- `fetchValid` in 1: `pcIn`/`instrIn` are valid this cycle.
- `pcIn` in XLEN: PC of the fetched instruction.
- `instrIn` in 32: fetched instruction word.
- `done` out 1: run finished (any outcome); sticky until reset.
- `pass` / `fail` / `timeout` out 1 each: outcome flags, one-hot when `done`.
- `histCount` out $clog2(DEPTH+1): valid entries held, saturates at DEPTH.
- `dumpValid` out 1: `dumpData` holds a history entry.
- `dumpData` out XLEN: history PC.
- `dumpLast` out 1: current entry is the newest (final) one.
- `dumpReady` in 1: consumer accepts entry when high with `dumpValid`.

## Operation
- FSM states: RUN, DUMP, HALT. Reset → RUN.
- RUN, `fetchValid`=1: write `pcIn` at `wrPtr`, `wrPtr` increments modulo DEPTH (wraps DEPTH-1→0, all DEPTH slots used), `histCount` +1 saturating.
- The halting instruction's PC is logged in the same cycle it is detected.
- RUN, `fetchValid` & `instrIn`==PASS_INSTR → HALT, `pass`=1.
- RUN, `fetchValid` & `instrIn`==FAIL_INSTR → DUMP, `fail`=1.
- RUN, cycle counter reaches TIMEOUT_CYCLES with no halt → DUMP, `timeout`=1. Counter counts every RUN cycle, width $clog2(TIMEOUT_CYCLES+1).
- Same cycle FAIL_INSTR and timeout: fail wins, `timeout` stays 0.
- DUMP: read pointer starts at oldest entry (0 if `histCount`<DEPTH, else `wrPtr`); one entry per accepted handshake; after the newest entry is accepted → HALT.
- DUMP entered with `histCount`=0 (timeout, no fetch ever): go directly to HALT, `dumpValid` never asserts.
- HALT: all inputs ignored, history frozen, flags held.
- Reset in any state (including mid-dump): back to RUN, pointers/counters/flags cleared; history RAM contents need not be cleared.

## Timing
- Reset values: `done`=`pass`=`fail`=`timeout`=0, `histCount`=0, `dumpValid`=0, `dumpLast`=0, `dumpData`=0.
- Outcome flags and `done` are registered: high in the cycle after the sampling edge of the halting fetch/timeout.
- `dumpValid` first rises the cycle after entering DUMP; `dumpData`/`dumpLast` stable while `dumpValid`=1 and `dumpReady`=0.
- Accepted entry on edge with `dumpValid`&`dumpReady`; next entry presented the following cycle (1 entry/cycle with `dumpReady` tied high). `dumpValid` drops the cycle after the `dumpLast` entry is accepted.
- `histCount` updates the cycle after the logging edge.

## Configuration
- `PC_TRACE_STOP_EN`: defined → adds input `stopPc` (XLEN) and output `debugStop` (1). In RUN, `fetchValid` & `pcIn`==`stopPc` → HALT with `done`=1, `debugStop`=1, no dump; PASS/FAIL on the same fetch take priority over stop. Undefined → ports absent, no PC-stop logic.

## Test plan
- Fetch PCs 0x00,0x04,…,0x10 then ECALL at 0x14 → `done`=`pass`=1 one cycle later, `histCount`=6, no dump.
- 14 fetches at 0x00..0x34 step 4, EBREAK at 0x34, DEPTH=10, `dumpReady`=1 → `fail`=1, dump 0x10,0x14,…,0x34 (10 entries), `dumpLast` only on 0x34.
- Same as above with `dumpReady` toggling every other cycle → identical sequence, data held while stalled.
- TIMEOUT_CYCLES=20, no fetches → `timeout`=1 at cycle 21, no `dumpValid`; with 3 fetches → dump of those 3 PCs.
- Reset asserted after 2nd dump entry → all outputs to reset values next cycle, new ECALL run passes normally.
- `PC_TRACE_STOP_EN`, `stopPc`=0x20, fetch 0x00..0x20 → `debugStop`=`done`=1, `pass`=`fail`=0.
